// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the instruction-fetch front end.
//   NOP_INSTR     - instruction word used for IF/ID bubbles
//   PC_RESET      - default fetch PC after reset
//   ADDR_W        - PC / instruction memory address width
//   fetch_entry_t - prefetch queue entry {instr, pc_plus_four}
//   fetch_state_t - request-channel states of fetch_queue_if
package mips_pkg;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] PC_RESET  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc_plus_four;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_BUSY = 2'd1,
    FQ_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular FIFO of fetch_entry_t with flush.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   i_flush      - empty the FIFO this cycle (push/pop ignored)
//   i_push       - write i_data (ignored when full unless popping too)
//   i_pop        - advance the head (ignored when empty)
//   i_data       - entry to write
//   o_head       - entry at the head (valid when !o_empty)
//   o_count      - number of stored entries, 0..DEPTH
//   o_full       - count == DEPTH
//   o_empty      - count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  fetch_entry_t           i_data,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-fetch front end feeding decode via IF/ID.
// Holds the fetch PC, issues single-outstanding req/ack reads to instruction
// memory, buffers returned words in a prefetch queue (fetch_fifo) and owns
// the IF/ID register, honouring decode stall and branch redirect.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   stall_d           - decode stall: hold IF/ID
//   pc_src_d          - branch taken in decode: flush and redirect
//   pc_branch_d       - redirect target (low two bits ignored)
//   imem_req/addr     - instruction memory request and word address
//   imem_ack/rdata    - response strobe and instruction word
//   cmd_d             - IF/ID instruction (NOP on bubble)
//   pc_plus_four_d    - IF/ID PC+4
//   valid_d           - cmd_d holds a real instruction
//   perf_bubble_cnt   - (FETCH_PERF_EN) cycles with !valid_d and !stall_d
//   perf_drop_cnt     - (FETCH_PERF_EN) flushed entries plus dropped acks
// Optional feature macro: FETCH_PERF_EN.
//
// state   | meaning
// FQ_IDLE | no request outstanding; may issue
// FQ_BUSY | request outstanding; ack delivers a word to the queue
// FQ_DROP | request outstanding but redirected; ack is discarded
module fetch_queue_if #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = mips_pkg::PC_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_d,
  input  logic              pc_src_d,
  input  logic [ADDR_W-1:0] pc_branch_d,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       cmd_d,
  output logic [ADDR_W-1:0] pc_plus_four_d,
  output logic              valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_bubble_cnt,
  output logic [15:0]       perf_drop_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  mips_pkg::fetch_state_t r_state;
  mips_pkg::fetch_state_t w_state_nxt;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_cmd;
  logic [ADDR_W-1:0] r_pc4;
  logic              r_valid;

  logic              w_issue;
  logic              w_push;
  logic              w_ack_drop;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_target;
  mips_pkg::fetch_entry_t w_push_data;
  mips_pkg::fetch_entry_t w_head;

  logic w_unused_lsb;
  assign w_unused_lsb = ^pc_branch_d[1:0];

  assign w_target = {pc_branch_d[ADDR_W-1:2], 2'b00};

  assign imem_req       = (r_state != mips_pkg::FQ_IDLE);
  assign imem_addr      = r_addr;
  assign cmd_d          = r_cmd;
  assign pc_plus_four_d = r_pc4;
  assign valid_d        = r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= mips_pkg::FQ_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Issue is held off during a redirect so no request goes out on the
  // wrong path; the queue space check covers the single outstanding word.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    w_ack_drop  = 1'b0;
    case (r_state)
      mips_pkg::FQ_IDLE: begin
        if (!pc_src_d && !w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = mips_pkg::FQ_BUSY;
        end
      end
      mips_pkg::FQ_BUSY: begin
        if (imem_ack) begin
          w_state_nxt = mips_pkg::FQ_IDLE;
          if (pc_src_d) w_ack_drop = 1'b1;
          else          w_push     = 1'b1;
        end else if (pc_src_d) begin
          w_state_nxt = mips_pkg::FQ_DROP;
        end
      end
      mips_pkg::FQ_DROP: begin
        if (imem_ack) begin
          w_state_nxt = mips_pkg::FQ_IDLE;
          w_ack_drop  = 1'b1;
        end
      end
      default: w_state_nxt = mips_pkg::FQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= PC_RESET;
      r_addr     <= PC_RESET;
    end else if (pc_src_d) begin
      r_fetch_pc <= w_target;
    end else if (w_issue) begin
      r_addr     <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
    end
  end

  assign w_push_data.instr        = imem_rdata;
  assign w_push_data.pc_plus_four = r_addr + ADDR_W'(4);

  assign w_pop = !pc_src_d && !stall_d && !w_empty;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (pc_src_d),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The queue head is only visible after its push edge, so an acked word
  // always spends at least one cycle in the queue before reaching IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd   <= mips_pkg::NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (pc_src_d) begin
      r_cmd   <= mips_pkg::NOP_INSTR;
      r_valid <= 1'b0;
    end else if (stall_d) begin
      r_cmd   <= r_cmd;
    end else if (!w_empty) begin
      r_cmd   <= w_head.instr;
      r_pc4   <= w_head.pc_plus_four;
      r_valid <= 1'b1;
    end else begin
      r_cmd   <= mips_pkg::NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_bubble_cnt;
  logic [15:0] r_drop_cnt;
  logic [16:0] w_drop_sum;

  // On redirect every queued entry is lost; pops are blocked that cycle.
  assign w_drop_sum = {1'b0, r_drop_cnt}
                    + (pc_src_d ? 17'(w_count) : 17'd0)
                    + 17'(w_ack_drop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (!r_valid && !stall_d && (r_bubble_cnt != 16'hFFFF))
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign perf_bubble_cnt = r_bubble_cnt;
  assign perf_drop_cnt   = r_drop_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^w_count;
`endif

endmodule

// File: tb/tb_fetch_queue_if.sv
// tb_fetch_queue_if: scoreboard bench for fetch_queue_if.
// A memory responder services requests from a per-test table of
// {expected address, ack latency}; a monitor pops expected IF/ID entries
// whenever the IF/ID register loads, and checks bubbles/redirects.
module tb_fetch_queue_if;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          lat;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d;
  logic        pc_src_d;
  logic [31:0] pc_branch_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] cmd_d;
  logic [31:0] pc_plus_four_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_bubble_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  logic        resp_ack;
  logic [31:0] resp_data;
  logic        stray_ack;

  assign imem_ack   = resp_ack | stray_ack;
  assign imem_rdata = stray_ack ? 32'hDEAD_BEEF : resp_data;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_d        (stall_d),
    .pc_src_d       (pc_src_d),
    .pc_branch_d    (pc_branch_d),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .cmd_d          (cmd_d),
    .pc_plus_four_d (pc_plus_four_d),
    .valid_d        (valid_d)
`ifdef FETCH_PERF_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  int bubbles     = 0;

  req_t         req_q[$];
  fetch_entry_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    req_t cur;
    resp_ack  = 1'b0;
    resp_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      resp_ack = 1'b0;
      if (!reset && imem_req && req_q.size() > 0) begin
        cur = req_q.pop_front();
        check("imem_addr", imem_addr, cur.addr);
        repeat (cur.lat - 1) begin @(posedge clk); #1; end
        resp_ack  = 1'b1;
        resp_data = mem_word(imem_addr);
      end
    end
  end

  // ---------------- IF/ID monitor ----------------
  logic ld_q    = 1'b0;
  logic redir_q = 1'b0;
  fetch_entry_t got_e;

  always @(posedge clk) begin
    ld_q    <= !reset && !stall_d && !pc_src_d;
    redir_q <= !reset && pc_src_d;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (redir_q) begin
        check("redirect_cmd", cmd_d, NOP_INSTR);
        check("redirect_valid", 32'(valid_d), 32'd0);
      end else if (ld_q) begin
        if (valid_d) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %08h, expected none", cmd_d);
          end else begin
            got_e = exp_q.pop_front();
            check("cmd_d", cmd_d, got_e.instr);
            check("pc_plus_four_d", pc_plus_four_d, got_e.pc_plus_four);
          end
        end else begin
          bubbles++;
          check("bubble_cmd", cmd_d, NOP_INSTR);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic add_req(input logic [31:0] a, input int lat);
    req_t r;
    r.addr = a;
    r.lat  = lat;
    req_q.push_back(r);
  endtask

  task automatic add_exp(input logic [31:0] a);
    fetch_entry_t e;
    e.instr        = mem_word(a);
    e.pc_plus_four = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    reset       = 1'b1;
    stall_d     = 1'b0;
    pc_src_d    = 1'b0;
    pc_branch_d = 32'h0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_cmd_d", cmd_d, 32'h0);
    check("rst_pc_plus_four_d", pc_plus_four_d, 32'h0);
    check("rst_valid_d", 32'(valid_d), 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_bubble", 32'(perf_bubble_cnt), 32'd0);
    check("rst_perf_drop", 32'(perf_drop_cnt), 32'd0);
`endif
    tick();
    tick();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (req_q.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    vectors++;
    if (req_q.size() != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_%s: %0d requests and %0d words left, expected 0",
               name, req_q.size(), exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      if (imem_req && imem_addr == a) begin
        found = 1;
        break;
      end
      tick();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL wait_%s: request to %08h not seen, expected within 100 cycles",
               name, a);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0;
`ifdef FETCH_PERF_EN
    logic [15:0] d0;
`endif
    reset       = 1'b1;
    stall_d     = 1'b0;
    pc_src_d    = 1'b0;
    pc_branch_d = 32'h0;
    stray_ack   = 1'b0;

    // Reset mid-request, stray ack after release, then one word from PC 0.
    do_reset();
    reset = 1'b0;
    repeat (3) tick();
    check("req_pending", 32'(imem_req), 32'd1);
    do_reset();
    add_req(32'h0, 1);
    add_exp(32'h0);
    reset     = 1'b0;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    drain("reset");

    // Streaming, 1-cycle ack, 8 words.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      add_req(32'(4 * k), 1);
      add_exp(32'(4 * k));
    end
    reset = 1'b0;
    drain("stream");

    // Variable latency 1, 5, 3.
    do_reset();
    add_req(32'h0, 1); add_exp(32'h0);
    add_req(32'h4, 5); add_exp(32'h4);
    add_req(32'h8, 3); add_exp(32'h8);
    b0    = bubbles;
    reset = 1'b0;
    drain("varlat");
    check("varlat_bubbles", 32'((bubbles - b0) >= 8), 32'd1);

    // Stall fill: queue stops at 4, no request while full, then 4 pops.
    do_reset();
    stall_d = 1'b1;
    for (int k = 0; k < 6; k++) begin
      add_req(32'(4 * k), 1);
      add_exp(32'(4 * k));
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("stall_cmd_hold", cmd_d, 32'h0);
      check("stall_valid_hold", 32'(valid_d), 32'd0);
      if (i >= 8) check("stall_no_req", 32'(imem_req), 32'd0);
    end
    stall_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_release_pop", 32'(valid_d), 32'd1);
    end
    drain("stall");

    // Redirect to 0x40 while the request to 0x10 is outstanding.
    do_reset();
    add_req(32'h00, 1); add_exp(32'h00);
    add_req(32'h04, 1); add_exp(32'h04);
    add_req(32'h08, 1); add_exp(32'h08);
    add_req(32'h0C, 1); add_exp(32'h0C);
    add_req(32'h10, 4);
    add_req(32'h40, 1); add_exp(32'h40);
    add_req(32'h44, 1); add_exp(32'h44);
    reset = 1'b0;
    wait_addr(32'h10, "redirect");
`ifdef FETCH_PERF_EN
    d0 = perf_drop_cnt;
`endif
    pc_src_d    = 1'b1;
    pc_branch_d = 32'h40;
    tick();
    pc_src_d = 1'b0;
    drain("redirect");
`ifdef FETCH_PERF_EN
    check("perf_drop_late_ack", 32'(perf_drop_cnt), 32'(d0) + 32'd1);
`endif

    // Redirect + stall + ack in the same cycle, target wraps through 0.
    do_reset();
    stall_d = 1'b1;
    add_req(32'h0, 1);
    add_req(32'h4, 1);
    add_req(32'h8, 1);
    add_req(32'hC, 1);
    add_req(32'hFFFF_FFF8, 1); add_exp(32'hFFFF_FFF8);
    add_req(32'hFFFF_FFFC, 1); add_exp(32'hFFFF_FFFC);
    add_req(32'h0000_0000, 1); add_exp(32'h0000_0000);
    reset = 1'b0;
    wait_addr(32'hC, "simul");
`ifdef FETCH_PERF_EN
    d0 = perf_drop_cnt;
`endif
    pc_src_d    = 1'b1;
    pc_branch_d = 32'hFFFF_FFFB;
    tick();
    pc_src_d = 1'b0;
`ifdef FETCH_PERF_EN
    check("perf_drop_flush", 32'(perf_drop_cnt), 32'(d0) + 32'd4);
`endif
    repeat (4) tick();
    stall_d = 1'b0;
    drain("simul");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

endmodule
